// File: rtl/rca_mp_sequencer.sv
// Multi-precision add sequencer: steps one external N-bit ripple-carry adder
// across WORDS slices, LS slice first, chaining carries through a register.
module rca_mp_sequencer #(
    parameter int N     = 16,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   sum,
    output logic                 cout,
    output logic [N-1:0]         rca_a,
    output logic [N-1:0]         rca_b,
    output logic                 rca_ci,
    input  logic [N-1:0]         rca_s,
    input  logic                 rca_co
);

    localparam int W  = N * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [KW-1:0]   k;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry_q;
    logic            last_slice;

    assign last_slice = (k == KW'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Carry register seeds from cin on capture, then follows the adder's carry each slice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k       <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        k       <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (k == KW'(i)) begin
                            sum[i*N +: N] <= rca_s;
                        end
                    end
                    carry_q <= rca_co;
                    if (last_slice) begin
                        cout <= rca_co;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Adder inputs are forced to zero outside RUN so the adder sees no stray activity.
    always_comb begin
        rca_a  = '0;
        rca_b  = '0;
        rca_ci = 1'b0;
        if (state == RUN) begin
            rca_ci = carry_q;
            for (int i = 0; i < WORDS; i++) begin
                if (k == KW'(i)) begin
                    rca_a = a_q[i*N +: N];
                    rca_b = b_q[i*N +: N];
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
